cond_logic_pred: RTL

Parametrised successor to the pipeline's conditional logic unit. It sits in the Execute stage and holds the architected NZCV flag register, with independent NZ and CV write groups. It evaluates all 16 condition codes against that register and gates a configurable number of write-enable channels, PC source and branch. It also supports a predicated-block mode in which one instruction imposes an extra condition on the next N valid instructions.

---
 rtl/cond_pkg.sv | 24 ++
 rtl/cond_eval_nzcv.sv | 39 +++
 rtl/cond_logic_pred.sv | 115 +++++++++++
 3 files changed

// File: rtl/cond_pkg.sv
// rtl/cond_pkg.sv - shared condition-code, flag-index and predicate-state definitions
package cond_pkg;

    typedef enum logic [3:0] {
        EQ = 4'h0, NE = 4'h1, CS = 4'h2, CC = 4'h3,
        MI = 4'h4, PL = 4'h5, VS = 4'h6, VC = 4'h7,
        HI = 4'h8, LS = 4'h9, GE = 4'hA, LT = 4'hB,
        GT = 4'hC, LE = 4'hD, AL = 4'hE, NV = 4'hF
    } cond_e;

    typedef enum logic {
        P_IDLE = 1'b0,
        P_PRED = 1'b1
    } pred_state_e;

    localparam int N_IDX = 3;
    localparam int Z_IDX = 2;
    localparam int C_IDX = 1;
    localparam int V_IDX = 0;

    localparam int FW_NZ = 1;
    localparam int FW_CV = 0;

endpackage

// File: rtl/cond_eval_nzcv.sv
// rtl/cond_eval_nzcv.sv - combinational ARM condition-code evaluator against an NZCV nibble
import cond_pkg::*;

module cond_eval_nzcv (
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       ok_o
);

    logic n, z, c, v;

    assign n = flags_i[N_IDX];
    assign z = flags_i[Z_IDX];
    assign c = flags_i[C_IDX];
    assign v = flags_i[V_IDX];

    always_comb begin
        ok_o = 1'b0;
        case (cond_e'(cond_i))
            EQ: ok_o = z;
            NE: ok_o = ~z;
            CS: ok_o = c;
            CC: ok_o = ~c;
            MI: ok_o = n;
            PL: ok_o = ~n;
            VS: ok_o = v;
            VC: ok_o = ~v;
            HI: ok_o = c & ~z;
            LS: ok_o = ~c | z;
            GE: ok_o = (n == v);
            LT: ok_o = (n != v);
            GT: ok_o = ~z & (n == v);
            LE: ok_o = z | (n != v);
            AL: ok_o = 1'b1;
            NV: ok_o = 1'b0;
        endcase
    end

endmodule

// File: rtl/cond_logic_pred.sv
// rtl/cond_logic_pred.sv - NZCV flag register, condition gating and predicated-block counter
import cond_pkg::*;

module cond_logic_pred #(
    parameter int NUM_WR   = 2,
    parameter int PRED_MAX = 4,
    parameter int CNT_W    = $clog2(PRED_MAX + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid_e,
    input  logic [3:0]        cond,
    input  logic [1:0]        flag_write,
    input  logic [3:0]        alu_flags,
    input  logic [NUM_WR-1:0] wr_en,
    input  logic              no_write,
    input  logic              pc_src,
    input  logic              branch_e,
    input  logic              pred_start,
    input  logic [CNT_W-1:0]  pred_len,
    input  logic [3:0]        pred_cond,
    output logic [NUM_WR-1:0] wr_en_p,
    output logic              pc_src_p,
    output logic              branch_taken,
    output logic              cond_ex,
    output logic [3:0]        flags_q,
    output logic              pred_active
);

    localparam logic [CNT_W-1:0] PRED_MAX_C = CNT_W'(PRED_MAX);

    pred_state_e      state_q, state_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [3:0]       pred_cond_q, pred_cond_d;
    logic [3:0]       flags_d;
    logic             own_ok, pred_eval_ok, pred_ok;

    cond_eval_nzcv u_own_eval (
        .cond_i  (cond),
        .flags_i (flags_q),
        .ok_o    (own_ok)
    );

    cond_eval_nzcv u_pred_eval (
        .cond_i  (pred_cond_q),
        .flags_i (flags_q),
        .ok_o    (pred_eval_ok)
    );

    assign pred_active = (count_q != '0);
    assign pred_ok     = ~pred_active | pred_eval_ok;
    // Folding reset into cond_ex forces every gated output low while reset is held.
    assign cond_ex     = reset & valid_e & own_ok & pred_ok;

    always_comb begin
        wr_en_p      = wr_en & {NUM_WR{cond_ex}};
        wr_en_p[0]   = wr_en_p[0] & ~no_write;
        pc_src_p     = pc_src & cond_ex;
        branch_taken = branch_e & cond_ex;
    end

    always_comb begin
        flags_d = flags_q;
        if (cond_ex && flag_write[FW_NZ]) begin
            flags_d[N_IDX] = alu_flags[N_IDX];
            flags_d[Z_IDX] = alu_flags[Z_IDX];
        end
        if (cond_ex && flag_write[FW_CV]) begin
            flags_d[C_IDX] = alu_flags[C_IDX];
            flags_d[V_IDX] = alu_flags[V_IDX];
        end
    end

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        pred_cond_d = pred_cond_q;
        case (state_q)
            P_IDLE: begin
                if (cond_ex && pred_start && (pred_len != '0)) begin
                    state_d     = P_PRED;
                    count_d     = (pred_len > PRED_MAX_C) ? PRED_MAX_C : pred_len;
                    pred_cond_d = pred_cond;
                end
            end
            P_PRED: begin
                // Members consume a slot whether or not they execute; a taken branch abandons the block.
                if (branch_taken) begin
                    count_d = '0;
                end else if (valid_e) begin
                    count_d = count_q - CNT_W'(1);
                end
                if (count_d == '0) begin
                    state_d = P_IDLE;
                end
            end
            default: state_d = P_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q     <= P_IDLE;
            count_q     <= '0;
            pred_cond_q <= AL;
            flags_q     <= 4'b0000;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            pred_cond_q <= pred_cond_d;
            flags_q     <= flags_d;
        end
    end

endmodule
